rgb_fade_pwm: RTL
=================

// Module: rgb_fade_pwm
// PURPOSE
//  Consumes the 6-bit rotating light pattern from the rainbow shift register and
//  drives the RGB LED pins. Each colour channel has a duty register that ramps one
//  LSB per ramp tick toward full-on or full-off, so colour changes cross-fade
//  instead of stepping. Duties are rendered as PWM. Sits between the shift register
//  and the top-level LED pins.
// PARAMETERS
//  PWM_BITS  8     duty/PWM counter width; PWM period = 2**PWM_BITS-1 cycles
//  RAMP_DIV  7812  clk cycles per ramp tick (full 0->max ramp ~= one light interval @12MHz)
//  INVERT    1     1: pins active-low (LED on = 0); 0: active-high
// PORTS
//  clk     in   1  system clock
//  rst_n   in   1  asynchronous active-low reset
//  en      in   1  1: run; 0: freeze counters/duties, force LEDs off
//  phase   in   6  pattern bits {q_6..q_1}; phase[0]=q_1
//  red     out  1  red LED pin (PWM, polarity per INVERT)
//  green   out  1  green LED pin
//  blue    out  1  blue LED pin
//  busy    out  1  1 while any channel duty != its target
// BEHAVIOUR
//  - Reset (rst_n=0, async): pwm_cnt=0, ramp_cnt=0, all duties=0, all channel FSMs
//    LOW, busy=0, red/green/blue = off level (INVERT). Applies immediately, mid-ramp too.
//  - Targets: tgt_r=phase[0], tgt_g=phase[2], tgt_b=phase[4] (120 deg apart); 1 -> DMAX,
//    0 -> 0, DMAX = 2**PWM_BITS-1. phase sampled every cycle, no synchroniser (same clk).
//  - pwm_cnt counts 0..DMAX-1, wraps to 0; advances only when en=1.
//  - ramp_cnt counts 0..RAMP_DIV-1; tick = (ramp_cnt==RAMP_DIV-1 && en); wraps on tick.
//  - Per-channel FSM, evaluated only on tick:
//      LOW     (duty=0):    tgt=1 -> RISING, duty+=1
//      RISING:              tgt=1 -> duty+=1, enter HIGH when duty reaches DMAX;
//                           tgt=0 -> FALLING, duty-=1 (reversal on same tick)
//      HIGH    (duty=DMAX): tgt=0 -> FALLING, duty-=1
//      FALLING:             tgt=0 -> duty-=1, enter LOW when duty reaches 0;
//                           tgt=1 -> RISING, duty+=1
//    Duty saturates: never wraps past 0 or DMAX. Target changes between ticks act at
//    the next tick only; a target that toggles and returns between ticks is ignored.
//  - Pin: on = (duty > pwm_cnt) && en; pin = on ^ INVERT. duty=0 -> never on;
//    duty=DMAX -> always on (while en). Pins and busy are registered: one clk after
//    the duty/pwm_cnt values they reflect.
//  - busy (registered) = OR over channels of (duty != target value).
//  - en=0: pwm_cnt, ramp_cnt, duties, FSM states held; pins forced off on next clk;
//    busy keeps reflecting held duty vs current target. en 0->1 resumes from held values.
//  - All three channels may step on the same tick independently.
// TESTING (sim params PWM_BITS=4 -> DMAX=15, RAMP_DIV=2, INVERT=1)
//  1 Reset: rst_n=0 mid-ramp (duty_r=7) -> red/green/blue=1, busy=0 immediately
//    (async); after release duty=0, pins stay 1 with phase=0.
//  2 Rise: phase=000001, en=1 -> busy=1 next clk; duty_r +1 every 2 clks, reaches 15
//    after 30 clks; red low for duty_r of every 15-cycle PWM period; busy=0 after.
//  3 Saturation/full-on: hold phase=000001 200 clks after rise -> duty_r stays 15,
//    red constant 0; green/blue constant 1.
//  4 Reversal: rise red to duty 6, set phase=000000 -> next tick duty 5, then
//    decrements to 0 in 5 more ticks; red constant 1 thereafter, busy=0.
//  5 Rotation: phase 000111 -> 001110 -> ... each 40 clks -> red/green/blue
//    ramps offset by 2 steps, no duty ever outside 0..15.
//  6 Enable: en=0 at duty_g=9 for 50 clks -> pins all 1, duty_g held 9;
//    en=1 -> ramp resumes from 9, PWM restarts from held pwm_cnt.

Source files
------------

// File: rtl/rgb_fade_pwm.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_fade_pwm
//  Purpose  : Cross-fading RGB LED driver. Takes the rotating 6-bit light
//             pattern from the rainbow shift register. Each colour channel
//             owns a duty register that ramps one LSB per ramp tick toward
//             full-on or full-off. The duties are rendered as PWM on the
//             LED pins.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    PWM_BITS  duty / PWM counter width; PWM period = 2**PWM_BITS-1 cycles
//    RAMP_DIV  clk cycles per ramp tick
//    INVERT    1: pins active-low (LED on = 0); 0: pins active-high
//  Ports
//    clk     in   system clock
//    rst_n   in   asynchronous active-low reset
//    en      in   1: run; 0: freeze counters/duties and force the LEDs off
//    phase   in   pattern bits {q_6..q_1}; phase[0]=q_1
//    red     out  red LED pin (PWM, polarity set by INVERT)
//    green   out  green LED pin
//    blue    out  blue LED pin
//    busy    out  1 while any channel duty differs from its target
// ============================================================================
module rgb_fade_pwm #(
    parameter int PWM_BITS = 8,
    parameter int RAMP_DIV = 7812,
    parameter bit INVERT   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [5:0] phase,
    output logic       red,
    output logic       green,
    output logic       blue,
    output logic       busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [PWM_BITS-1:0] c_zero     = '0;
    localparam logic [PWM_BITS-1:0] c_one      = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] c_dmax     = {PWM_BITS{1'b1}};
    // The PWM counter stops one short of DMAX. Because of this, duty=DMAX is
    // on for every cycle of the period, and duty=0 is never on.
    localparam logic [PWM_BITS-1:0] c_pwm_last = c_dmax - c_one;

    localparam int                  c_ramp_w    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [c_ramp_w-1:0] c_ramp_zero = '0;
    localparam logic [c_ramp_w-1:0] c_ramp_one  = c_ramp_w'(1);
    localparam logic [c_ramp_w-1:0] c_ramp_last = c_ramp_w'(RAMP_DIV - 1);

    localparam logic c_off = INVERT;

    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_RISING  = 2'd1,
        ST_HIGH    = 2'd2,
        ST_FALLING = 2'd3
    } chan_state_t;

    // ------------------------------------------------------------------------
    // Shared counters
    // ------------------------------------------------------------------------
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [c_ramp_w-1:0] r_ramp_cnt;
    logic                w_tick;

    logic [2:0]          w_on;
    logic [2:0]          w_mismatch;
    logic [2:0]          r_pin;
    logic                r_busy;

    // Only the even pattern bits select colours (120 degrees apart).
    logic                w_unused_phase;
    assign w_unused_phase = ^{phase[5], phase[3], phase[1]};

    assign w_tick = (r_ramp_cnt == c_ramp_last) && en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt  <= c_zero;
            r_ramp_cnt <= c_ramp_zero;
        end else if (en) begin
            r_pwm_cnt  <= (r_pwm_cnt == c_pwm_last) ? c_zero : (r_pwm_cnt + c_one);
            r_ramp_cnt <= w_tick ? c_ramp_zero : (r_ramp_cnt + c_ramp_one);
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel fade FSM and duty register
    //   channel 0 = red   (phase[0])
    //   channel 1 = green (phase[2])
    //   channel 2 = blue  (phase[4])
    // ------------------------------------------------------------------------
    for (genvar c = 0; c < 3; c++) begin : g_ch
        chan_state_t         r_state;
        chan_state_t         w_state_nxt;
        logic [PWM_BITS-1:0] r_duty;
        logic [PWM_BITS-1:0] w_duty_nxt;
        logic [PWM_BITS-1:0] w_duty_up;
        logic [PWM_BITS-1:0] w_duty_dn;
        logic                w_tgt;

        assign w_tgt     = phase[2*c];
        assign w_duty_up = r_duty + c_one;
        assign w_duty_dn = r_duty - c_one;

        // Target changes are only looked at on a tick. Because of this, a
        // glitch that returns to its old value between ticks leaves no trace.
        // The can-step guards keep the duty saturated, even if the state and
        // the duty ever disagree.
        always_comb begin
            w_state_nxt = r_state;
            w_duty_nxt  = r_duty;
            if (w_tick) begin
                case (r_state)
                    ST_LOW: begin
                        if (w_tgt) begin
                            w_duty_nxt  = w_duty_up;
                            w_state_nxt = (w_duty_up == c_dmax) ? ST_HIGH : ST_RISING;
                        end
                    end
                    ST_HIGH: begin
                        if (!w_tgt) begin
                            w_duty_nxt  = w_duty_dn;
                            w_state_nxt = (w_duty_dn == c_zero) ? ST_LOW : ST_FALLING;
                        end
                    end
                    default: begin
                        // RISING / FALLING: follow the target. When the
                        // target changes, the direction reverses on the same
                        // tick.
                        if (w_tgt) begin
                            if (r_duty != c_dmax) begin
                                w_duty_nxt  = w_duty_up;
                                w_state_nxt = (w_duty_up == c_dmax) ? ST_HIGH : ST_RISING;
                            end else begin
                                w_state_nxt = ST_HIGH;
                            end
                        end else begin
                            if (r_duty != c_zero) begin
                                w_duty_nxt  = w_duty_dn;
                                w_state_nxt = (w_duty_dn == c_zero) ? ST_LOW : ST_FALLING;
                            end else begin
                                w_state_nxt = ST_LOW;
                            end
                        end
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= ST_LOW;
                r_duty  <= c_zero;
            end else begin
                r_state <= w_state_nxt;
                r_duty  <= w_duty_nxt;
            end
        end

        assign w_mismatch[c] = (r_duty != (w_tgt ? c_dmax : c_zero));
        assign w_on[c]       = (r_duty > r_pwm_cnt) && en;
    end

    // ------------------------------------------------------------------------
    // Registered pins and busy flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pin  <= {3{c_off}};
            r_busy <= 1'b0;
        end else begin
            r_pin  <= w_on ^ {3{c_off}};
            r_busy <= |w_mismatch;
        end
    end

    assign red   = r_pin[0];
    assign green = r_pin[1];
    assign blue  = r_pin[2];
    assign busy  = r_busy;

endmodule
`default_nettype wire
